// File: rtl/exec_control_pkg.sv
// Shared definitions for the execute-stage controller:
// opcodes, functs, ALU operation codes and FSM encodings.
package prj_definition;

  localparam int DATA_INDEX_LIMIT = 31;
  localparam int OPRN_INDEX_LIMIT = 5;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_MULI  = 6'h1d;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SLL = 6'h01;

  localparam logic [5:0] ALU_NONE = 6'h00;
  localparam logic [5:0] ALU_ADD  = 6'h01;
  localparam logic [5:0] ALU_SUB  = 6'h02;
  localparam logic [5:0] ALU_MUL  = 6'h03;
  localparam logic [5:0] ALU_SRL  = 6'h04;
  localparam logic [5:0] ALU_SLL  = 6'h05;
  localparam logic [5:0] ALU_AND  = 6'h06;
  localparam logic [5:0] ALU_OR   = 6'h07;
  localparam logic [5:0] ALU_NOR  = 6'h08;
  localparam logic [5:0] ALU_SLT  = 6'h09;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_t;

  function automatic logic [5:0] rtype_oprn(
    input logic [5:0] funct
  );
    logic [5:0] code;
    code = ALU_NONE;
    case (funct)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_MUL:  code = ALU_MUL;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_NOR:  code = ALU_NOR;
      FN_SLT:  code = ALU_SLT;
      FN_SRL:  code = ALU_SRL;
      FN_SLL:  code = ALU_SLL;
      default: code = ALU_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [5:0] itype_oprn(
    input logic [5:0] opc
  );
    logic [5:0] code;
    code = ALU_NONE;
    case (opc)
      OPC_ADDI: code = ALU_ADD;
      OPC_MULI: code = ALU_MUL;
      OPC_SLTI: code = ALU_SLT;
      OPC_ANDI: code = ALU_AND;
      OPC_ORI:  code = ALU_OR;
      OPC_LW:   code = ALU_ADD;
      OPC_SW:   code = ALU_ADD;
      OPC_LUI:  code = ALU_SLL;
      OPC_BEQ:  code = ALU_SUB;
      OPC_BNE:  code = ALU_SUB;
      default:  code = ALU_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/exec_control_decode.sv
// Combinational instruction decode for the execute stage:
// operand select, ALU code and writeback/branch sideband.
module exec_decode
  import prj_definition::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [31:0]               instr,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic [DATA_WIDTH-1:0]     rt_data,
  output logic [DATA_WIDTH-1:0]     op1,
  output logic [DATA_WIDTH-1:0]     op2,
  output logic [OPRN_WIDTH-1:0]     oprn,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output br_t                       br_type,
  output logic                      illegal
);

  logic [5:0] opc;
  logic [5:0] fn;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_z;
  logic [DATA_WIDTH-1:0] shamt_z;
  logic [REG_ADDR_WIDTH-1:0] rd_idx;
  logic [REG_ADDR_WIDTH-1:0] rt_idx;
  logic r_type;
  logic r_rs;
  logic r_sh;
  logic i_sx;
  logic i_zx;
  logic i_lui;
  logic i_br;
  logic unused_rs;

  assign opc     = instr[31:26];
  assign fn      = instr[5:0];
  assign imm_s   = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
  assign imm_z   = {{(DATA_WIDTH-16){1'b0}}, instr[15:0]};
  assign shamt_z = {{(DATA_WIDTH-5){1'b0}}, instr[10:6]};
  assign rd_idx  = REG_ADDR_WIDTH'(instr[15:11]);
  assign rt_idx  = REG_ADDR_WIDTH'(instr[20:16]);

  // Register values arrive on rs_data/rt_data, so the rs field is not needed.
  assign unused_rs = ^instr[25:21];

  assign r_type = (opc == OPC_RTYPE);

  assign r_rs = r_type &&
    (fn == FN_ADD || fn == FN_SUB ||
     fn == FN_MUL || fn == FN_AND ||
     fn == FN_OR  || fn == FN_NOR ||
     fn == FN_SLT);

  assign r_sh = r_type &&
    (fn == FN_SRL || fn == FN_SLL);

  assign i_sx =
    (opc == OPC_ADDI) || (opc == OPC_MULI) ||
    (opc == OPC_SLTI) || (opc == OPC_LW) ||
    (opc == OPC_SW);

  assign i_zx =
    (opc == OPC_ANDI) || (opc == OPC_ORI);

  assign i_lui = (opc == OPC_LUI);

  assign i_br =
    (opc == OPC_BEQ) || (opc == OPC_BNE);

  always_comb begin
    op1     = '0;
    op2     = '0;
    oprn    = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    br_type = BR_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      r_rs: begin
        op1     = rs_data;
        op2     = rt_data;
        oprn    = OPRN_WIDTH'(rtype_oprn(fn));
        wr_en   = 1'b1;
        wr_addr = rd_idx;
      end
      r_sh: begin
        op1     = rt_data;
        op2     = shamt_z;
        oprn    = OPRN_WIDTH'(rtype_oprn(fn));
        wr_en   = 1'b1;
        wr_addr = rd_idx;
      end
      i_sx: begin
        op1     = rs_data;
        op2     = imm_s;
        oprn    = OPRN_WIDTH'(itype_oprn(opc));
        wr_en   = (opc != OPC_SW);
        wr_addr = rt_idx;
      end
      i_zx: begin
        op1     = rs_data;
        op2     = imm_z;
        oprn    = OPRN_WIDTH'(itype_oprn(opc));
        wr_en   = 1'b1;
        wr_addr = rt_idx;
      end
      i_lui: begin
        op1     = imm_z;
        op2     = DATA_WIDTH'(16);
        oprn    = OPRN_WIDTH'(itype_oprn(opc));
        wr_en   = 1'b1;
        wr_addr = rt_idx;
      end
      i_br: begin
        op1     = rs_data;
        op2     = rt_data;
        oprn    = OPRN_WIDTH'(itype_oprn(opc));
        wr_addr = rt_idx;
        br_type = (opc == OPC_BEQ) ? BR_EQ : BR_NE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/exec_control.sv
// Execute-stage controller: registers ALU operands on accept,
// captures the ALU result one cycle later and hands it downstream.
module exec_control
  import prj_definition::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [31:0]               INSTR,
  input  logic [DATA_WIDTH-1:0]     RS_DATA,
  input  logic [DATA_WIDTH-1:0]     RT_DATA,
  output logic [DATA_WIDTH-1:0]     ALU_OP1,
  output logic [DATA_WIDTH-1:0]     ALU_OP2,
  output logic [OPRN_WIDTH-1:0]     ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]     ALU_OUT,
  input  logic                      ALU_ZERO,
  output logic                      RES_VALID,
  input  logic                      RES_READY,
  output logic [DATA_WIDTH-1:0]     RES_DATA,
  output logic                      RES_ZERO,
  output logic                      BR_TAKEN,
  output logic                      WR_EN,
  output logic [REG_ADDR_WIDTH-1:0] WR_ADDR,
  output logic                      ILLEGAL
);

  state_t state;
  state_t next;
  logic   in_ready;
  logic   accept;
  br_t    br_q;

  logic [DATA_WIDTH-1:0]     dec_op1;
  logic [DATA_WIDTH-1:0]     dec_op2;
  logic [OPRN_WIDTH-1:0]     dec_oprn;
  logic                      dec_wr_en;
  logic [REG_ADDR_WIDTH-1:0] dec_wr_addr;
  br_t                       dec_br;
  logic                      dec_ill;

  exec_decode #(
    .DATA_WIDTH     (DATA_WIDTH),
    .OPRN_WIDTH     (OPRN_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_decode (
    .instr   (INSTR),
    .rs_data (RS_DATA),
    .rt_data (RT_DATA),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .oprn    (dec_oprn),
    .wr_en   (dec_wr_en),
    .wr_addr (dec_wr_addr),
    .br_type (dec_br),
    .illegal (dec_ill)
  );

  assign IN_READY = in_ready;
  assign accept   = IN_VALID & in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next     = state;
    in_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (IN_VALID) next = S_EXEC;
      end
      S_EXEC: begin
        next = S_DONE;
      end
      S_DONE: begin
        in_ready = RES_READY;
        if (RES_READY) begin
          next = IN_VALID ? S_EXEC : S_IDLE;
        end
      end
      default: begin
        next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_OP1   <= '0;
      ALU_OP2   <= '0;
      ALU_OPRN  <= '0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      ILLEGAL   <= 1'b0;
      br_q      <= BR_NONE;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_ZERO  <= 1'b0;
      BR_TAKEN  <= 1'b0;
    end else begin
      if (accept) begin
        ALU_OP1  <= dec_op1;
        ALU_OP2  <= dec_op2;
        ALU_OPRN <= dec_oprn;
        WR_EN    <= dec_wr_en;
        WR_ADDR  <= dec_wr_addr;
        ILLEGAL  <= dec_ill;
        br_q     <= dec_br;
      end
      // ILLEGAL and br_q here still describe the instruction now in EXEC.
      if (state == S_EXEC) begin
        RES_VALID <= 1'b1;
        RES_DATA  <= ILLEGAL ? '0 : ALU_OUT;
        RES_ZERO  <= ALU_ZERO;
        BR_TAKEN  <= ((br_q == BR_EQ) &  ALU_ZERO) |
                     ((br_q == BR_NE) & ~ALU_ZERO);
      end else if (state == S_DONE && RES_READY) begin
        RES_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_control.sv
// Randomized scoreboard bench for exec_control with an attached
// behavioural ALU and an instruction-level reference model.
module tb_exec_control;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic [31:0] RS_DATA;
  logic [31:0] RT_DATA;
  logic [31:0] ALU_OP1;
  logic [31:0] ALU_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;
  logic        RES_VALID;
  logic        RES_READY;
  logic [31:0] RES_DATA;
  logic        RES_ZERO;
  logic        BR_TAKEN;
  logic        WR_EN;
  logic [4:0]  WR_ADDR;
  logic        ILLEGAL;

  exec_control dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INSTR     (INSTR),
    .RS_DATA   (RS_DATA),
    .RT_DATA   (RT_DATA),
    .ALU_OP1   (ALU_OP1),
    .ALU_OP2   (ALU_OP2),
    .ALU_OPRN  (ALU_OPRN),
    .ALU_OUT   (ALU_OUT),
    .ALU_ZERO  (ALU_ZERO),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_DATA  (RES_DATA),
    .RES_ZERO  (RES_ZERO),
    .BR_TAKEN  (BR_TAKEN),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .ILLEGAL   (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Combinational ALU sitting downstream of the controller.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = 32'h0;
    case (ALU_OPRN)
      6'h01: alu_res = ALU_OP1 + ALU_OP2;
      6'h02: alu_res = ALU_OP1 - ALU_OP2;
      6'h03: alu_res = ALU_OP1 * ALU_OP2;
      6'h04: alu_res = ALU_OP1 >> ALU_OP2;
      6'h05: alu_res = ALU_OP1 << ALU_OP2;
      6'h06: alu_res = ALU_OP1 & ALU_OP2;
      6'h07: alu_res = ALU_OP1 | ALU_OP2;
      6'h08: alu_res = ~(ALU_OP1 | ALU_OP2);
      6'h09: alu_res = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: alu_res = 32'h0;
    endcase
  end
  assign ALU_OUT  = alu_res;
  assign ALU_ZERO = (alu_res == 32'h0);

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [5:0]  oprn;
    logic        zero;
    logic        chk_zero;
    logic        br;
    logic        wen;
    logic [4:0]  wa;
    logic        ill;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   rd_idx   = 0;
  int   n_vec    = 0;
  int   errs     = 0;
  bit   mon_en   = 0;
  bit   rdy_rand = 0;
  bit   hold_lo  = 0;
  bit   seen     = 0;
  logic [31:0] s_data;
  logic [4:0]  s_wa;
  logic        s_zero, s_br, s_wen, s_ill;

  logic [5:0] opc_tab [16] = '{
    6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h1d, 6'h0a, 6'h0c,
    6'h0d, 6'h23, 6'h2b, 6'h0f, 6'h04, 6'h05, 6'h3f, 6'h02
  };
  logic [5:0] fn_tab [10] = '{
    6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h02, 6'h01, 6'h08
  };

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    if (act !== want) begin
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
      errs++;
    end
  endtask

  // Instruction semantics straight from the ISA description.
  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [31:0] sx, zx, sh;
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    sh = {27'h0, ins[10:6]};
    e = '{default: 0};
    e.op1 = a;
    e.wen = 1'b1;
    e.wa  = ins[20:16];
    case (ins[31:26])
      6'h00: begin
        e.wa  = ins[15:11];
        e.op2 = b;
        case (ins[5:0])
          6'h20: begin e.oprn = 6'h01; e.res = a + b; end
          6'h22: begin e.oprn = 6'h02; e.res = a - b; end
          6'h2c: begin e.oprn = 6'h03; e.res = a * b; end
          6'h24: begin e.oprn = 6'h06; e.res = a & b; end
          6'h25: begin e.oprn = 6'h07; e.res = a | b; end
          6'h27: begin e.oprn = 6'h08; e.res = ~(a | b); end
          6'h2a: begin
            e.oprn = 6'h09;
            e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          end
          6'h02: begin
            e.oprn = 6'h04; e.op1 = b; e.op2 = sh; e.res = b >> ins[10:6];
          end
          6'h01: begin
            e.oprn = 6'h05; e.op1 = b; e.op2 = sh; e.res = b << ins[10:6];
          end
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.oprn = 6'h01; e.op2 = sx; e.res = a + sx; end
      6'h1d: begin e.oprn = 6'h03; e.op2 = sx; e.res = a * sx; end
      6'h0a: begin
        e.oprn = 6'h09; e.op2 = sx;
        e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
      end
      6'h0c: begin e.oprn = 6'h06; e.op2 = zx; e.res = a & zx; end
      6'h0d: begin e.oprn = 6'h07; e.op2 = zx; e.res = a | zx; end
      6'h23: begin e.oprn = 6'h01; e.op2 = sx; e.res = a + sx; end
      6'h2b: begin
        e.oprn = 6'h01; e.op2 = sx; e.res = a + sx; e.wen = 1'b0;
      end
      6'h0f: begin
        e.oprn = 6'h05; e.op1 = zx; e.op2 = 32'd16;
        e.res = {ins[15:0], 16'h0};
      end
      6'h04: begin
        e.oprn = 6'h02; e.op2 = b; e.res = a - b; e.wen = 1'b0;
        e.br = (a == b);
      end
      6'h05: begin
        e.oprn = 6'h02; e.op2 = b; e.res = a - b; e.wen = 1'b0;
        e.br = (a != b);
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.op1 = 0; e.op2 = 0; e.oprn = 0; e.res = 0;
      e.wen = 0; e.wa = 0; e.br = 0;
    end
    e.zero     = (e.res == 32'h0);
    e.chk_zero = !e.ill;
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    bit   acc;
    exp_t e;
    IN_VALID = 1'b1;
    INSTR    = ins;
    RS_DATA  = a;
    RT_DATA  = b;
    for (int k = 0; k < 64; k++) begin
      #2;
      acc = IN_READY;
      if (acc) begin
        e = model(ins, a, b);
        e.acc = cyc;
        q.push_back(e);
        n_vec++;
      end
      @(posedge CLK);
      @(negedge CLK);
      if (acc) begin
        IN_VALID = 1'b0;
        return;
      end
    end
    $display("FAIL accept_timeout: got IN_READY low want high for %h", ins);
    errs++;
    IN_VALID = 1'b0;
  endtask

  task automatic ready_loop();
    forever begin
      @(negedge CLK);
      #1;
      if (hold_lo) RES_READY = 1'b0;
      else if (rdy_rand) RES_READY = ($urandom_range(0, 3) != 0);
      else RES_READY = 1'b1;
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (!mon_en) begin
        seen   = 0;
        rd_idx = q.size();
      end else if (RES_VALID) begin
        if (rd_idx >= q.size()) begin
          $display("FAIL unexpected_result: got RES_VALID 1 want 0");
          errs++;
        end else begin
          e = q[rd_idx];
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(e.acc + 2));
            seen   = 1;
            s_data = RES_DATA; s_zero = RES_ZERO; s_br = BR_TAKEN;
            s_wen  = WR_EN;    s_wa   = WR_ADDR;  s_ill = ILLEGAL;
          end else begin
            chk("hold_data", RES_DATA, s_data);
            chk("hold_zero", 32'(RES_ZERO), 32'(s_zero));
            chk("hold_br", 32'(BR_TAKEN), 32'(s_br));
            chk("hold_wen", 32'(WR_EN), 32'(s_wen));
            chk("hold_wa", 32'(WR_ADDR), 32'(s_wa));
            chk("hold_ill", 32'(ILLEGAL), 32'(s_ill));
          end
          if (!RES_READY) chk("in_ready_stall", 32'(IN_READY), 32'd0);
          if (RES_READY) begin
            chk("alu_op1", ALU_OP1, e.op1);
            chk("alu_op2", ALU_OP2, e.op2);
            chk("alu_oprn", 32'(ALU_OPRN), 32'(e.oprn));
            chk("res_data", RES_DATA, e.res);
            if (e.chk_zero) chk("res_zero", 32'(RES_ZERO), 32'(e.zero));
            chk("br_taken", 32'(BR_TAKEN), 32'(e.br));
            chk("wr_en", 32'(WR_EN), 32'(e.wen));
            chk("wr_addr", 32'(WR_ADDR), 32'(e.wa));
            chk("illegal", 32'(ILLEGAL), 32'(e.ill));
            rd_idx++;
            seen = 0;
          end
        end
      end else if (rd_idx < q.size() && cyc > q[rd_idx].acc + 2) begin
        $display("FAIL res_timeout: got RES_VALID 0 want 1 (cycle %0d)", cyc);
        errs++;
        rd_idx++;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
    chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
    chk({tag, "_alu_op1"}, ALU_OP1, 32'd0);
    chk({tag, "_alu_op2"}, ALU_OP2, 32'd0);
    chk({tag, "_alu_oprn"}, 32'(ALU_OPRN), 32'd0);
    chk({tag, "_res_data"}, RES_DATA, 32'd0);
    chk({tag, "_res_zero"}, 32'(RES_ZERO), 32'd0);
    chk({tag, "_br_taken"}, 32'(BR_TAKEN), 32'd0);
    chk({tag, "_wr_en"}, 32'(WR_EN), 32'd0);
    chk({tag, "_wr_addr"}, 32'(WR_ADDR), 32'd0);
    chk({tag, "_illegal"}, 32'(ILLEGAL), 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && rd_idx < q.size(); k++) @(negedge CLK);
    if (rd_idx < q.size()) begin
      $display("FAIL drain: got %0d pending want 0", q.size() - rd_idx);
      errs++;
    end
  endtask

  initial begin
    logic [31:0] w, a, b;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    INSTR     = 32'h0;
    RS_DATA   = 32'h0;
    RT_DATA   = 32'h0;
    RES_READY = 1'b0;
    fork
      ready_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge CLK);
    chk_reset_outputs("rst");
    RST    = 1'b0;
    mon_en = 1;
    @(negedge CLK);

    // Directed cases
    issue({6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20}, 32'd7, 32'd5);
    issue({6'h0f, 5'd0, 5'd9, 16'hABCD}, 32'h1234, 32'h5678);
    issue({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h55, 32'h55);
    issue({6'h05, 5'd1, 5'd2, 16'h0010}, 32'h55, 32'h55);
    issue({6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd1, 32'd0);
    issue({6'h3f, 26'h155_5555}, 32'hDEAD, 32'hBEEF);
    issue({6'h00, 5'd1, 5'd6, 5'd7, 5'd4, 6'h01}, 32'h0, 32'h8000_0003);
    drain();

    // Backpressure: 4 stalled cycles in DONE, then back-to-back accept
    hold_lo = 1;
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'd100, 32'd58);
    fork
      issue({6'h0d, 5'd1, 5'd12, 16'h00F0}, 32'h0F0F_0000, 32'h0);
      begin
        repeat (5) @(negedge CLK);
        hold_lo = 0;
      end
    join
    drain();

    // Randomized traffic
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      w = $urandom;
      w[31:26] = opc_tab[$urandom_range(0, 15)];
      if (w[31:26] == 6'h00) w[5:0] = fn_tab[$urandom_range(0, 9)];
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(w, a, b);
    end
    drain();

    // Reset while an instruction sits in EXEC
    rdy_rand = 0;
    mon_en   = 0;
    @(negedge CLK);
    issue({6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20}, 32'd9, 32'd9);
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("rst_exec");
    RST = 1'b0;
    @(negedge CLK);
    mon_en = 1;
    @(negedge CLK);
    issue({6'h0c, 5'd1, 5'd10, 16'h8001}, 32'hFFFF_FFFF, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

endmodule
